// File: rtl/psum_adder_ctrl.sv
// psum_adder_ctrl: feeds PE psums to the threshold adder and packs its result bits into ofmaps BRAM words; PSUM_ADDER_CTRL_PERF_EN adds perf counters
module psum_adder_ctrl #(
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
  parameter int WORD_W = 32,
  parameter int PIPE_LAT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH:0] cfg_num_pixels,
  input  logic [11:0] cfg_in_channel,
  input  logic [4:0] cfg_kernel_size,
  input  logic psum_valid,
  output logic psum_ready,
  output logic [11:0] adder_in_channel,
  output logic [4:0] adder_kernel_size,
  output logic adder_i_valid,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] adder_address_in,
  input  logic adder_o_data,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] adder_address_out,
  input  logic adder_o_valid,
  output logic bram_we,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-$clog2(WORD_W)-1:0] bram_addr,
  output logic [WORD_W-1:0] bram_wdata,
  output logic busy,
  output logic done
`ifdef PSUM_ADDER_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls
`endif
);
  localparam int AW = OFMAPS_BRAM_ADDR_WIDTH;
  localparam int WB = $clog2(WORD_W);
  localparam int IW = $clog2(PIPE_LAT + 2);
  localparam int BW = AW - WB;
  localparam logic [AW:0] PIX_ONE = (AW+1)'(1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW:0] num_pixels_q, num_pixels_d, issued_q, issued_d;
  logic [11:0] in_channel_q, in_channel_d;
  logic [4:0] kernel_size_q, kernel_size_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [WORD_W-1:0] pack_q, pack_d, pack_n, bram_wdata_q, bram_wdata_d;
  logic bram_we_q, bram_we_d;
  logic [BW-1:0] bram_addr_q, bram_addr_d;
  logic retire, last_bit;
  logic [WB-1:0] b;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign psum_ready = state_q == RUN && issued_q < num_pixels_q;
  assign adder_i_valid = psum_valid & psum_ready;
  assign adder_address_in = issued_q[AW-1:0];
  assign adder_in_channel = in_channel_q;
  assign adder_kernel_size = kernel_size_q;
  assign bram_we = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign b = adder_address_out[WB-1:0];
  assign retire = adder_o_valid && busy && inflight_q != '0;
  assign last_bit = b == WB'(WORD_W - 1) || {1'b0, adder_address_out} == num_pixels_q - PIX_ONE;
  always_comb begin
    pack_n = pack_q;
    pack_n[b] = adder_o_data;
  end
  always_comb begin
    state_d = state_q;
    num_pixels_d = num_pixels_q;
    in_channel_d = in_channel_q;
    kernel_size_d = kernel_size_q;
    issued_d = adder_i_valid ? issued_q + PIX_ONE : issued_q;
    inflight_d = inflight_q + IW'(adder_i_valid) - IW'(retire);
    pack_d = retire ? (last_bit ? '0 : pack_n) : pack_q;
    bram_we_d = retire && last_bit;
    bram_addr_d = bram_we_d ? adder_address_out[AW-1:WB] : bram_addr_q;
    bram_wdata_d = bram_we_d ? pack_n : bram_wdata_q;
    case (state_q)
      IDLE: if (start) begin
        num_pixels_d = cfg_num_pixels;
        in_channel_d = cfg_in_channel;
        kernel_size_d = cfg_kernel_size;
        issued_d = '0;
        inflight_d = '0;
        pack_d = '0;
        state_d = cfg_num_pixels == '0 ? DONE : RUN;
      end
      RUN: state_d = issued_d >= num_pixels_q ? DRAIN : RUN;
      DRAIN: state_d = inflight_q == '0 && !bram_we_d ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_pixels_q <= '0;
      in_channel_q <= '0;
      kernel_size_q <= '0;
      issued_q <= '0;
      inflight_q <= '0;
      pack_q <= '0;
      bram_we_q <= 1'b0;
      bram_addr_q <= '0;
      bram_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      num_pixels_q <= num_pixels_d;
      in_channel_q <= in_channel_d;
      kernel_size_q <= kernel_size_d;
      issued_q <= issued_d;
      inflight_q <= inflight_d;
      pack_q <= pack_d;
      bram_we_q <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end
`ifdef PSUM_ADDER_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;
  logic perf_clr;
  assign perf_clr = state_q == IDLE && start;
  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
  always_comb begin
    perf_cycles_d = perf_clr ? '0 : perf_cycles_q + (busy ? 32'd1 : 32'd0);
    perf_stalls_d = perf_clr ? '0 : perf_stalls_q + (psum_ready && !psum_valid ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end
`endif
endmodule

// File: tb/tb_psum_adder_ctrl.sv
// tb_psum_adder_ctrl: directed bench for psum_adder_ctrl with a fixed-latency adder model
module tb_psum_adder_ctrl;
  localparam int AW = 12;
  localparam int WW = 32;
  localparam int LAT = 10;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, psum_valid = 1'b0;
  logic [AW:0] cfg_num_pixels = '0;
  logic [11:0] cfg_in_channel = 12'd64;
  logic [4:0] cfg_kernel_size = 5'b00010;
  logic psum_ready, adder_i_valid, adder_o_data, adder_o_valid, bram_we, busy, done;
  logic [11:0] adder_in_channel;
  logic [4:0] adder_kernel_size;
  logic [AW-1:0] adder_address_in, adder_address_out;
  logic [AW-6:0] bram_addr;
  logic [WW-1:0] bram_wdata;
`ifdef PSUM_ADDER_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif
  psum_adder_ctrl #(.OFMAPS_BRAM_ADDR_WIDTH(AW), .WORD_W(WW), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_pixels(cfg_num_pixels),
    .cfg_in_channel(cfg_in_channel), .cfg_kernel_size(cfg_kernel_size),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .adder_in_channel(adder_in_channel), .adder_kernel_size(adder_kernel_size),
    .adder_i_valid(adder_i_valid), .adder_address_in(adder_address_in),
    .adder_o_data(adder_o_data), .adder_address_out(adder_address_out), .adder_o_valid(adder_o_valid),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata), .busy(busy), .done(done)
`ifdef PSUM_ADDER_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );
  always #5 clk = ~clk;
  logic [LAT-1:0] pv = '0;
  logic [AW-1:0] pa [LAT];
  logic all_ones = 1'b0;
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], adder_i_valid};
    pa[0] <= adder_i_valid ? adder_address_in : '0;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end
  assign adder_o_valid = pv[LAT-1];
  assign adder_address_out = pa[LAT-1];
  assign adder_o_data = all_ones | pa[LAT-1][0];
  int cyc = 0, n_iss = 0, n_wr = 0, n_done = 0, n_busy = 0, iflt = 0, max_iflt = 0;
  int start_cyc = 0, done_cyc = 0, we_cyc = 0;
  logic prev_busy = 1'b0, done_busy = 1'b0, done_prev_busy = 1'b0;
  int iss_addr [1024];
  int iss_cyc [1024];
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  always @(negedge clk) begin
    cyc++;
    if (start) start_cyc = cyc;
    if (!rst_n) iflt = 0;
    else begin
      if (adder_i_valid) iflt++;
      if (adder_o_valid && iflt > 0) iflt--;
    end
    if (iflt > max_iflt) max_iflt = iflt;
    if (adder_i_valid) begin
      if (n_iss < 1024) begin
        iss_addr[n_iss] = int'(adder_address_in);
        iss_cyc[n_iss] = cyc;
      end
      n_iss++;
    end
    if (bram_we) begin
      if (n_wr < 64) begin
        wr_addr[n_wr] = 32'(bram_addr);
        wr_data[n_wr] = bram_wdata;
      end
      n_wr++;
      we_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      done_busy = busy;
      done_prev_busy = prev_busy;
    end
    if (busy) n_busy++;
    prev_busy = busy;
  end
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic run_tile(input int n, input bit tog, input int stop_iss, input int repulse);
    int c, i0, d0;
    c = 0;
    i0 = n_iss;
    d0 = n_done;
    @(posedge clk); #1;
    cfg_num_pixels = 13'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    psum_valid = 1'b1;
    while (n_done == d0 && c < 400 && !(stop_iss > 0 && n_iss - i0 >= stop_iss)) begin
      @(posedge clk); #1;
      c++;
      start = c == repulse;
      if (c == repulse) begin
        cfg_num_pixels = 13'd5;
        cfg_kernel_size = 5'b00100;
      end
      if (tog) psum_valid = ~psum_valid;
    end
    psum_valid = 1'b0;
    start = 1'b0;
    if (stop_iss == 0) chk("tile_done_seen", n_done - d0, 1);
  endtask
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask
  int i0, w0, d0, b0, err;
  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_psum_ready", psum_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_bram_wdata", bram_wdata, 0);
    chk("rst_kernel_size", adder_kernel_size, 0);
    chk("rst_in_channel", adder_in_channel, 0);
    rst_n = 1'b1;
    i0 = n_iss; w0 = n_wr; d0 = n_done;
    run_tile(64, 1'b0, 0, 0);
    settle();
    chk("t1_issues", n_iss - i0, 64);
    err = 0;
    for (int k = 0; k < 64; k++) if (iss_addr[i0+k] != k) err++;
    chk("t1_addr_seq", err, 0);
    chk("t1_issue_span", iss_cyc[i0+63] - iss_cyc[i0], 63);
    chk("t1_writes", n_wr - w0, 2);
    chk("t1_wr0_addr", wr_addr[w0], 0);
    chk("t1_wr0_data", wr_data[w0], 32'hAAAAAAAA);
    chk("t1_wr1_addr", wr_addr[w0+1], 1);
    chk("t1_wr1_data", wr_data[w0+1], 32'hAAAAAAAA);
    chk("t1_done_once", n_done - d0, 1);
    chk("t1_done_after_we", done_cyc - we_cyc, 1);
    chk("t1_busy_at_done", done_busy, 0);
    chk("t1_busy_before_done", done_prev_busy, 1);
    chk("t1_kernel_size", adder_kernel_size, 5'b00010);
    chk("t1_in_channel", adder_in_channel, 12'd64);
    all_ones = 1'b1;
    i0 = n_iss; w0 = n_wr; b0 = n_busy;
    run_tile(40, 1'b1, 0, 0);
    chk("t2_issues", n_iss - i0, 40);
    chk("t2_writes", n_wr - w0, 2);
    chk("t2_wr0_addr", wr_addr[w0], 0);
    chk("t2_wr0_data", wr_data[w0], 32'hFFFFFFFF);
    chk("t2_wr1_addr", wr_addr[w0+1], 1);
    chk("t2_wr1_data", wr_data[w0+1], 32'h000000FF);
    chk("t2_max_inflight_ok", max_iflt <= LAT, 1);
`ifdef PSUM_ADDER_CTRL_PERF_EN
    chk("t2_perf_stalls", perf_stalls, 39);
    chk("t2_perf_cycles", perf_cycles, n_busy - b0);
`endif
    settle();
    all_ones = 1'b0;
    i0 = n_iss; w0 = n_wr; d0 = n_done;
    run_tile(0, 1'b0, 0, 0);
    settle();
    chk("t3_issues", n_iss - i0, 0);
    chk("t3_writes", n_wr - w0, 0);
    chk("t3_done_once", n_done - d0, 1);
    chk("t3_done_latency", done_cyc - start_cyc, 1);
    cfg_kernel_size = 5'b00010;
    i0 = n_iss; w0 = n_wr;
    run_tile(64, 1'b0, 0, 20);
    settle();
    chk("t4_issues", n_iss - i0, 64);
    chk("t4_writes", n_wr - w0, 2);
    chk("t4_kernel_size", adder_kernel_size, 5'b00010);
    cfg_kernel_size = 5'b00010;
    i0 = n_iss;
    run_tile(64, 1'b0, 20, 0);
    chk("t5_partial_issues_ok", n_iss - i0 >= 20 && n_iss - i0 < 64, 1);
    psum_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_psum_ready", psum_ready, 0);
    chk("t5_rst_i_valid", adder_i_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_bram_we", bram_we, 0);
    chk("t5_rst_kernel_size", adder_kernel_size, 0);
    chk("t5_rst_wdata", bram_wdata, 0);
    psum_valid = 1'b0;
    settle();
    rst_n = 1'b1;
    w0 = n_wr;
    repeat (15) @(posedge clk); #1;
    chk("t5_stale_no_write", n_wr - w0, 0);
    chk("t5_idle_after_stale", busy, 0);
    i0 = n_iss; w0 = n_wr;
    run_tile(32, 1'b0, 0, 0);
    settle();
    chk("t5_issues", n_iss - i0, 32);
    chk("t5_writes", n_wr - w0, 1);
    chk("t5_wr_addr", wr_addr[w0], 0);
    chk("t5_wr_data", wr_data[w0], 32'hAAAAAAAA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end
endmodule
